// File: rtl/win_scan_fsm.sv
// rtl/win_scan_fsm.sv - sequential K-in-a-row win scanner for an N x N board
// Optional WIN_MASK_EN adds win_mask, a one-hot-per-cell map of the winning line.
module win_scan_fsm #(
    parameter int N       = 3,
    parameter int WIN_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*N*N-1:0]       gBoard,
    output logic                   busy,
    output logic                   done,
    output logic                   gameIsDone,
    output logic [1:0]             winner,
    output logic [$clog2(N)-1:0]   win_row,
    output logic [$clog2(N)-1:0]   win_col,
    output logic [1:0]             win_dir
`ifdef WIN_MASK_EN
    ,
    output logic [N*N-1:0]         win_mask
`endif
);

    localparam int CW = $clog2(N);
    localparam int AW = $clog2(N*N);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t            state_q, state_d;
    logic [2*N*N-1:0]  board_q;
    logic [AW-1:0]     a_q;
    logic [CW-1:0]     row_q, col_q;

    logic              hit, hit_p, last, full;
    logic [1:0]        hit_dir;
    logic [1:0]        chk_r, chk_d, chk_dr, chk_dl;
    logic              fit_r, fit_d, fit_dl;

    // Returns {all cells occupied and same player, player of the anchor cell}.
    function automatic logic [1:0] line_chk(input logic [2*N*N-1:0] b, input int r, input int c,
                                            input int dr, input int dc);
        logic ok;
        logic p0;
        int   idx;
        ok = 1'b1;
        p0 = b[2*(r*N+c)+1];
        for (int k = 0; k < WIN_LEN; k++) begin
            idx = (r + dr*k)*N + (c + dc*k);
            if (!b[2*idx]) ok = 1'b0;
            if (b[2*idx+1] != p0) ok = 1'b0;
        end
        return {ok, p0};
    endfunction

`ifdef WIN_MASK_EN
    function automatic logic [N*N-1:0] line_mask(input int r, input int c, input int dr, input int dc);
        logic [N*N-1:0] m;
        m = '0;
        for (int k = 0; k < WIN_LEN; k++) m[(r + dr*k)*N + (c + dc*k)] = 1'b1;
        return m;
    endfunction

    logic [N*N-1:0] mask_q;
    assign win_mask = mask_q;
`endif

    always_comb begin
        fit_r   = int'(col_q) + WIN_LEN <= N;
        fit_d   = int'(row_q) + WIN_LEN <= N;
        fit_dl  = (int'(col_q) >= WIN_LEN - 1) && fit_d;
        chk_r   = fit_r           ? line_chk(board_q, int'(row_q), int'(col_q), 0,  1) : 2'b00;
        chk_d   = fit_d           ? line_chk(board_q, int'(row_q), int'(col_q), 1,  0) : 2'b00;
        chk_dr  = (fit_r && fit_d) ? line_chk(board_q, int'(row_q), int'(col_q), 1,  1) : 2'b00;
        chk_dl  = fit_dl          ? line_chk(board_q, int'(row_q), int'(col_q), 1, -1) : 2'b00;
        hit     = 1'b1;
        hit_p   = 1'b0;
        hit_dir = 2'b00;
        if (chk_r[1])       begin hit_p = chk_r[0];  hit_dir = 2'b00; end
        else if (chk_d[1])  begin hit_p = chk_d[0];  hit_dir = 2'b01; end
        else if (chk_dr[1]) begin hit_p = chk_dr[0]; hit_dir = 2'b10; end
        else if (chk_dl[1]) begin hit_p = chk_dl[0]; hit_dir = 2'b11; end
        else                hit = 1'b0;
        last = (a_q == AW'(N*N-1));
        full = 1'b1;
        for (int c = 0; c < N*N; c++) if (!board_q[2*c]) full = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        busy       = (state_q == SCAN);
        done       = (state_q == REPORT);
        gameIsDone = (winner != 2'b00);
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (hit || last) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Results only change on the SCAN->REPORT transition so they hold across a new scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_q <= '0;
            a_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            winner  <= 2'b00;
            win_row <= '0;
            win_col <= '0;
            win_dir <= 2'b00;
`ifdef WIN_MASK_EN
            mask_q  <= '0;
`endif
        end else if (state_q == IDLE) begin
            if (start) begin
                board_q <= gBoard;
                a_q     <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end
        end else if (state_q == SCAN) begin
            if (hit) begin
                winner  <= {1'b1, hit_p};
                win_row <= row_q;
                win_col <= col_q;
                win_dir <= hit_dir;
`ifdef WIN_MASK_EN
                case (hit_dir)
                    2'b00:   mask_q <= line_mask(int'(row_q), int'(col_q), 0,  1);
                    2'b01:   mask_q <= line_mask(int'(row_q), int'(col_q), 1,  0);
                    2'b10:   mask_q <= line_mask(int'(row_q), int'(col_q), 1,  1);
                    default: mask_q <= line_mask(int'(row_q), int'(col_q), 1, -1);
                endcase
`endif
            end else if (last) begin
                winner  <= full ? 2'b01 : 2'b00;
                win_row <= '0;
                win_col <= '0;
                win_dir <= 2'b00;
`ifdef WIN_MASK_EN
                mask_q  <= '0;
`endif
            end else begin
                a_q <= a_q + AW'(1);
                if (col_q == CW'(N-1)) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

endmodule
